// File: rtl/text_pkg.sv
// Shared constants and types for the text-cell RAM writer.
package text_pkg;
  localparam int TEXT_ROWS   = 32;
  localparam int TEXT_COLS   = 32;
  localparam int TEXT_ADDR_W = 10;
  localparam int TEXT_ROW_W  = $clog2(TEXT_ROWS);
  localparam int TEXT_COL_W  = $clog2(TEXT_COLS);

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } writer_state_t;
endpackage

// File: rtl/text_ram_writer_if.sv
// Character stream, RAM write port and status bundle of the text RAM writer.
// master: character source / top level; slave: the writer itself.
interface text_ram_writer_if;
  import text_pkg::*;

  logic                   wr_window;
  logic                   char_valid;
  logic [7:0]             char_data;
  logic                   char_ready;
  logic [TEXT_ADDR_W-1:0] ram_addr;
  logic [7:0]             ram_din;
  logic                   ram_we;
  logic                   bus_own;
  logic [TEXT_ROW_W-1:0]  cursor_row;
  logic [TEXT_COL_W-1:0]  cursor_col;
  logic                   busy;

  modport master (
    output wr_window, char_valid, char_data,
    input  char_ready, ram_addr, ram_din, ram_we, bus_own,
           cursor_row, cursor_col, busy
  );

  modport slave (
    input  wr_window, char_valid, char_data,
    output char_ready, ram_addr, ram_din, ram_we, bus_own,
           cursor_row, cursor_col, busy
  );
endinterface

// File: rtl/text_ram_writer_cursor.sv
// Cursor row/column register pair. Priority: home > newline > advance.
// Advance wraps the column into the next row and the last cell back to 0,0.
module text_cursor
  import text_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  newline,
  input  logic                  home,
  output logic [TEXT_ROW_W-1:0] row,
  output logic [TEXT_COL_W-1:0] col
);
  localparam logic [TEXT_ROW_W-1:0] ROW_ONE = 1;
  localparam logic [TEXT_COL_W-1:0] COL_ONE = 1;
  localparam logic [TEXT_COL_W-1:0] COL_MAX = TEXT_COL_W'(TEXT_COLS - 1);

  logic [TEXT_ROW_W-1:0] r_row;
  logic [TEXT_COL_W-1:0] r_col;

  // Cursor update; row arithmetic wraps naturally because the grid is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (home) begin
      r_row <= '0;
      r_col <= '0;
    end else if (newline) begin
      r_row <= r_row + ROW_ONE;
      r_col <= '0;
    end else if (advance) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + ROW_ONE;
      end else begin
        r_col <= r_col + COL_ONE;
      end
    end
  end

  assign row = r_row;
  assign col = r_col;
endmodule

// File: rtl/text_ram_writer.sv
// Text-cell RAM writer: accepts characters, writes them under the cursor,
// handles line feed and form feed (full-screen clear).
// Optional macro CLEAR_ON_RESET_EN: come out of reset already clearing.
module text_ram_writer
  import text_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h00
) (
  input logic              clk,
  input logic              reset,
  text_ram_writer_if.slave bus
);
  localparam logic [TEXT_ADDR_W:0] CNT_ONE = 1;

`ifdef CLEAR_ON_RESET_EN
  localparam writer_state_t RESET_STATE = ST_CLEAR;
  localparam logic          RESET_BUSY  = 1'b1;
`else
  localparam writer_state_t RESET_STATE = ST_IDLE;
  localparam logic          RESET_BUSY  = 1'b0;
`endif

  writer_state_t          r_state, w_state_next;
  // Next clear address; the top bit set means address 1023 has been issued.
  logic [TEXT_ADDR_W:0]   r_clr_cnt, w_clr_cnt_next;
  logic [TEXT_ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [7:0]             r_ram_din, w_ram_din_next;
  logic                   r_ram_we, w_ram_we_next;
  logic                   r_busy, w_busy_next;
  logic                   w_char_ready, w_xfer;
  logic                   w_adv, w_nl, w_home;
  logic [TEXT_ROW_W-1:0]  w_row;
  logic [TEXT_COL_W-1:0]  w_col;

  assign w_char_ready = (r_state == ST_IDLE) && bus.wr_window;
  assign w_xfer       = w_char_ready && bus.char_valid;

  text_cursor u_cursor (
    .clk     (clk),
    .reset   (reset),
    .advance (w_adv),
    .newline (w_nl),
    .home    (w_home),
    .row     (w_row),
    .col     (w_col)
  );

  // State and output registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RESET_STATE;
      r_clr_cnt  <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
      r_busy     <= RESET_BUSY;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_ram_addr <= w_ram_addr_next;
      r_ram_din  <= w_ram_din_next;
      r_ram_we   <= w_ram_we_next;
      r_busy     <= w_busy_next;
    end
  end

  // Next-state and next-output decode; a write is issued one cycle ahead of the strobe.
  always_comb begin
    w_state_next    = r_state;
    w_clr_cnt_next  = r_clr_cnt;
    w_ram_addr_next = r_ram_addr;
    w_ram_din_next  = r_ram_din;
    w_ram_we_next   = 1'b0;
    w_busy_next     = r_busy;
    w_adv           = 1'b0;
    w_nl            = 1'b0;
    w_home          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (bus.char_data == CHAR_FF) begin
            // Address 0 is issued right away so the clear starts next cycle.
            w_state_next    = ST_CLEAR;
            w_busy_next     = 1'b1;
            w_ram_addr_next = '0;
            w_ram_din_next  = FILL_CHAR;
            w_ram_we_next   = 1'b1;
            w_clr_cnt_next  = CNT_ONE;
          end else if (bus.char_data == CHAR_LF) begin
            w_nl = 1'b1;
          end else begin
            w_state_next    = ST_WRITE;
            w_ram_addr_next = {w_row, w_col};
            w_ram_din_next  = bus.char_data;
            w_ram_we_next   = 1'b1;
            w_adv           = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        if (r_clr_cnt[TEXT_ADDR_W]) begin
          // The strobe for address 1023 is active this cycle.
          w_state_next   = ST_IDLE;
          w_busy_next    = 1'b0;
          w_home         = 1'b1;
          w_clr_cnt_next = '0;
        end else if (bus.wr_window) begin
          w_ram_addr_next = r_clr_cnt[TEXT_ADDR_W-1:0];
          w_ram_din_next  = FILL_CHAR;
          w_ram_we_next   = 1'b1;
          w_clr_cnt_next  = r_clr_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.char_ready = w_char_ready;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.ram_we     = r_ram_we;
  assign bus.bus_own    = r_ram_we;
  assign bus.cursor_row = w_row;
  assign bus.cursor_col = w_col;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_text_ram_writer.sv
// Randomized bench for text_ram_writer against a cursor/RAM-image model.
module tb_text_ram_writer;
  localparam logic [7:0] FILL = 8'h2E;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] FF   = 8'h0C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_ram_writer_if bus ();

  text_ram_writer #(.FILL_CHAR(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: cursor position and expected RAM image (-1 = never written)
  int m_row = 0;
  int m_col = 0;
  int model_ram [1024];
  int shadow    [1024];
  int wcount    [1024];
  int total_we  = 0;
  int own_err   = 0;
  int win_viol  = 0;
  int hold_err  = 0;
  int last_wait = 0;
  int last_we_addr = -1;
  logic win_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // observed RAM traffic
  always @(posedge clk) win_prev <= bus.wr_window;
  always @(negedge clk) begin
    if (bus.bus_own !== bus.ram_we) own_err++;
    if (!reset && bus.ram_we === 1'b1) begin
      wcount[bus.ram_addr]++;
      shadow[bus.ram_addr] = int'(bus.ram_din);
      total_we++;
      if (!win_prev) win_viol++;
    end
  end

  function automatic logic [7:0] rand_print();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (c == LF || c == FF);
    return c;
  endfunction

  // send one character, window held low for 'idle' cycles first
  task automatic send_byte(input logic [7:0] c, input int idle);
    int n;
    int exp_addr;
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    if (idle > 0) begin
      bus.wr_window = 1'b0;
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        if (bus.char_ready !== 1'b0 || bus.ram_we !== 1'b0) hold_err++;
        @(posedge clk); #1;
      end
      bus.wr_window = 1'b1;
    end
    @(negedge clk);
    n = 0;
    while (bus.char_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (n >= 50) begin
      check("accept_timeout", n, 0);
      bus.char_valid = 1'b0;
      return;
    end
    exp_addr = m_row * 32 + m_col;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'($urandom);
    if (c == LF) begin
      m_col = 0;
      m_row = (m_row + 1) % 32;
      check("lf_no_we", bus.ram_we, 0);
      check("lf_row", bus.cursor_row, m_row);
      check("lf_col", bus.cursor_col, m_col);
      check("lf_ready_again", bus.char_ready, 1);
    end else begin
      model_ram[exp_addr] = int'(c);
      m_col = m_col + 1;
      if (m_col == 32) begin
        m_col = 0;
        m_row = (m_row + 1) % 32;
      end
      check("wr_we", bus.ram_we, 1);
      check("wr_addr", bus.ram_addr, exp_addr);
      check("wr_din", bus.ram_din, c);
      check("wr_ready_low", bus.char_ready, 0);
      check("wr_row", bus.cursor_row, m_row);
      check("wr_col", bus.cursor_col, m_col);
      last_we_addr = int'(bus.ram_addr);
      @(posedge clk); #1;
      check("wr_we_one_cycle", bus.ram_we, 0);
    end
  endtask

  task automatic clear_screen(input bit toggle);
    int c;
    int bad;
    for (int a = 0; a < 1024; a++) wcount[a] = 0;
    total_we = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = FF;
    bus.wr_window  = 1'b1;
    @(negedge clk);
    check("ff_ready", bus.char_ready, 1);
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    check("ff_first_we", bus.ram_we, 1);
    check("ff_first_addr", bus.ram_addr, 0);
    check("ff_busy", bus.busy, 1);
    check("ff_ready_low", bus.char_ready, 0);
    c = 0;
    while (bus.busy === 1'b1 && c < 4000) begin
      c++;
      if (toggle) bus.wr_window = ((c % 150) < 100);
      @(posedge clk); #1;
    end
    bus.wr_window = 1'b1;
    #1;
    check("clr_busy_done", bus.busy, 0);
    if (!toggle) check("clr_cycles", c, 1024);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (wcount[a] != 1) bad++;
    check("clr_each_once", bad, 0);
    check("clr_total_we", total_we, 1024);
    for (int a = 0; a < 1024; a++) model_ram[a] = int'(FILL);
    m_row = 0;
    m_col = 0;
    check("clr_row", bus.cursor_row, 0);
    check("clr_col", bus.cursor_col, 0);
    check("clr_ready", bus.char_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad;
    logic we_seen;
    for (int a = 0; a < 1024; a++) begin
      model_ram[a] = -1;
      shadow[a]    = -1;
      wcount[a]    = 0;
    end
    reset          = 1'b1;
    bus.wr_window  = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", bus.ram_we, 0);
    check("rst_own", bus.bus_own, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_din", bus.ram_din, 0);
    check("rst_row", bus.cursor_row, 0);
    check("rst_col", bus.cursor_col, 0);
`ifdef CLEAR_ON_RESET_EN
    check("rst_busy", bus.busy, 1);
`else
    check("rst_busy", bus.busy, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    bus.wr_window = 1'b1;
`ifdef CLEAR_ON_RESET_EN
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    check("por_clear_done", bus.busy, 0);
    check("por_clear_we", total_we, 1024);
    for (int a = 0; a < 1024; a++) model_ram[a] = int'(FILL);
`endif

    // first character lands at 0,0
    send_byte(8'h41, 0);
    check("first_addr", last_we_addr, 0);
    check("first_col", bus.cursor_col, 1);

    // end of row 0 wraps into row 1, then a line feed
    for (int i = 0; i < 31; i++) send_byte(rand_print(), 0);
    send_byte(8'h42, 0);
    check("row1_addr", last_we_addr, 32);
    send_byte(LF, 0);
    check("lf_row2", bus.cursor_row, 2);
    check("lf_col0", bus.cursor_col, 0);
    send_byte(LF, 0);
    check("lf_back_to_back", last_wait, 0);

    // held request with the window closed
    hold_err = 0;
    send_byte(rand_print(), 20);
    check("hold_no_xfer", hold_err, 0);
    check("hold_same_cycle", last_wait, 0);

    // randomized mix of printables and line feeds with window gaps
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 5) == 0) send_byte(LF, $urandom_range(0, 3));
      else send_byte(rand_print(), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end

    // drive the cursor to 31,31 and write the last cell
    while (m_row != 31) send_byte(LF, 0);
    while (m_col != 31) send_byte(rand_print(), 0);
    send_byte(8'h43, 0);
    check("corner_addr", last_we_addr, 1023);
    check("corner_row", bus.cursor_row, 0);
    check("corner_col", bus.cursor_col, 0);

    // clears: window continuously open, then gated 100 high / 50 low
    clear_screen(1'b0);
    send_byte(rand_print(), 0);
    clear_screen(1'b1);
    for (int t = 0; t < 40; t++) send_byte(rand_print(), $urandom_range(0, 1));

    bad = 0;
    for (int a = 0; a < 1024; a++) if (shadow[a] != model_ram[a]) bad++;
    check("ram_image", bad, 0);
    check("bus_own_tracks_we", own_err, 0);
    check("we_only_in_window", win_viol, 0);

    // reset in the middle of a clear
    bus.char_valid = 1'b1;
    bus.char_data  = FF;
    bus.wr_window  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(bus.ram_we === 1'b1 && bus.ram_addr == 10'd500) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("rst_mid_timeout", n, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_we_drop", bus.ram_we, 0);
    check("rst_mid_own_drop", bus.bus_own, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    m_row = 0;
    m_col = 0;
    @(negedge clk);
`ifdef CLEAR_ON_RESET_EN
    check("rst_mid_busy", bus.busy, 1);
    check("rst_mid_ready", bus.char_ready, 0);
    n = 0;
    while (bus.ram_we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_restart_addr", bus.ram_addr, 0);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("rst_mid_clear_done", bus.busy, 0);
    @(posedge clk); #1;
`else
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_idle_ready", bus.char_ready, 1);
    we_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      we_seen = we_seen | bus.ram_we;
    end
    check("rst_mid_no_we", we_seen, 0);
    @(posedge clk); #1;
`endif
    send_byte(8'h5A, 0);
    check("post_rst_addr", last_we_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/text_ram_writer.md
# text_ram_writer

Upstream writer for the 32x32 text-cell RAM that feeds the character display stage. Accepts a stream of character codes over a valid/ready handshake, writes each into the cell under a hardware cursor, and handles line-feed and clear-screen control codes. It owns the RAM's single address/write port only while the display is not scanning, and signals ownership so the top level can mux the address.

## Interface
Parameters:
- FILL_CHAR, 8'h00, value written to every cell by a clear.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- wr_window  input  1  high when the RAM port is free (display not reading). The top level guarantees it stays high at least 2 cycles before falling.
- char_valid  input  1  char_data is valid.
- char_data  input  8  character code.
- char_ready  output  1  writer accepts char_data this cycle.
- ram_addr  output  10  cell address {row[4:0], col[4:0]}.
- ram_din  output  8  write data.
- ram_we  output  1  write strobe, one cycle per cell.
- bus_own  output  1  writer drives ram_addr; top muxes address on this.
- cursor_row  output  5  current cursor row.
- cursor_col  output  5  current cursor column.
- busy  output  1  clear sequence in progress.

## Operation
- States: IDLE, WRITE, CLEAR.
- IDLE: char_ready = wr_window. Transfer occurs on char_valid && char_ready.
  - 0x0C (form feed): go CLEAR, clear address counter = 0.
  - 0x0A (line feed): col <= 0, row <= row+1 (31 wraps to 0). No RAM write. Stay IDLE.
  - Any other code: latch ram_addr = {row,col}, ram_din = char_data, go WRITE. Advance cursor: col+1; col 31 -> col 0 and row+1; row 31, col 31 -> 0,0.
- WRITE: ram_we = 1, bus_own = 1, char_ready = 0. Returns to IDLE next cycle. Completes even if wr_window falls.
- CLEAR: busy = 1, char_ready = 0. On each cycle with wr_window high: ram_addr = counter, ram_din = FILL_CHAR, ram_we = 1, counter+1. When wr_window is low: ram_we = 0, bus_own = 0, counter holds. After the write of address 1023: cursor <= 0,0, go IDLE.
- bus_own = ram_we at all times.
- Char_data is ignored while char_ready is low. The sender holds char_valid and char_data until the transfer occurs.

## Timing
- All outputs are registered except char_ready, which is combinational from state and wr_window.
- Reset values: state IDLE, ram_addr 0, ram_din 0, ram_we 0, bus_own 0, cursor 0,0, busy 0.
- Printable char accepted in cycle N: ram_we high in cycle N+1 only. Cursor shows the advanced value from N+1.
- Throughput: 1 printable char per 2 cycles; 1 line feed per cycle.
- Line feed accepted in cycle N: cursor updated in N+1.
- Clear with wr_window continuously high: 1024 consecutive ram_we cycles starting the cycle after acceptance. busy falls, and char_ready may rise, the cycle after the last write.
- Reset asserted mid-WRITE or mid-CLEAR: ram_we drops immediately. The clear is abandoned and the RAM is left partially cleared, unless CLEAR_ON_RESET_EN is defined.

## Configuration
- CLEAR_ON_RESET_EN defined: on reset release the state is CLEAR with counter 0 and busy 1. The full clear runs before the first char is accepted.
- Macro undefined: reset leaves the state in IDLE, and RAM contents are untouched.

## Structure
- Shared package text_pkg holds:
  - TEXT_ROWS = 32, TEXT_COLS = 32, TEXT_ADDR_W = 10;
  - CHAR_LF = 8'h0A, CHAR_FF = 8'h0C;
  - the writer state enum.
- One sub-module, text_cursor: row/col register pair with an advance input (with wrap), a newline input and a home input. Used by the writer for cursor tracking.

## Test plan
- Reset then send 0x41 with wr_window=1 -> ram_we one cycle at addr 0, din 0x41; cursor 0,1; char_ready low for exactly that cycle.
- Send 32 printable chars then 0x42 -> 0x42 written at addr 32 (row 1, col 0). Then send 0x0A -> cursor 2,0 with no ram_we.
- Cursor at 31,31, send 0x43 -> written at addr 1023; cursor wraps to 0,0.
- Send 0x0C with wr_window toggling 100 high / 50 low -> ram_we only when the window is high; addresses 0..1023 each written exactly once with FILL_CHAR; busy deasserts afterwards; cursor 0,0.
- Hold char_valid with wr_window=0 for 20 cycles -> no transfer and no ram_we. Raise wr_window -> transfer in the same cycle.
- Assert reset mid-clear at addr 500 -> ram_we low immediately. With CLEAR_ON_RESET_EN defined, the clear restarts at addr 0 after release; without it, the state is IDLE.
